// File: rtl/branch_station.sv
// -----------------------------------------------------------------------------
// branch_station
//   Two-entry in-order reservation station for control-transfer instructions
//   (j/jal/jr/beq/bne/bgez/bltz). Entries wait for their source operands on the
//   common data bus. Only the head entry is ever presented downstream.
//
// Ports
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   flush                       synchronous discard of every entry
//   issue_valid / issue_ready   dispatch handshake (ready = count < DEPTH)
//   issue_inst, issue_addr      instruction word and its address
//   issue_vj/vk, issue_qj/qk    operand values and producer tags (tag 0 = ready)
//   cdb_valid/tag/data          common data bus broadcast
//   out_valid / out_ready       head presentation handshake
//   out_inst/addr/rs/rt/qj/qk   head entry fields, straight from registers
//   count                       number of occupied entries (0..2)
//
// Configuration
//   BRANCH_STATION_ISSUE_FWD_EN  when defined, an issuing instruction captures a
//                                same-cycle CDB broadcast for its own tags.
//                                When undefined, issue_ready drops for that
//                                cycle so dispatch retries after the broadcast.
// -----------------------------------------------------------------------------
module branch_station #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] issue_inst,
    input  logic [31:0] issue_addr,
    input  logic [31:0] issue_vj,
    input  logic [31:0] issue_vk,
    input  logic [4:0]  issue_qj,
    input  logic [4:0]  issue_qk,
    input  logic        cdb_valid,
    input  logic [4:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic [31:0] out_rs,
    output logic [31:0] out_rt,
    output logic [4:0]  out_qj,
    output logic [4:0]  out_qk,
    output logic [1:0]  count
);
    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [DEPTH-1:0] validReg, validNext;
    logic [31:0]      instReg [DEPTH];
    logic [31:0]      instNext [DEPTH];
    logic [31:0]      addrReg [DEPTH];
    logic [31:0]      addrNext [DEPTH];
    logic [31:0]      vjReg [DEPTH];
    logic [31:0]      vjNext [DEPTH];
    logic [31:0]      vkReg [DEPTH];
    logic [31:0]      vkNext [DEPTH];
    logic [4:0]       qjReg [DEPTH];
    logic [4:0]       qjNext [DEPTH];
    logic [4:0]       qkReg [DEPTH];
    logic [4:0]       qkNext [DEPTH];
    logic [1:0]       countReg, countNext;

    // Per-entry view after this cycle's CDB capture.
    logic [31:0]      capVj [DEPTH];
    logic [31:0]      capVk [DEPTH];
    logic [4:0]       capQj [DEPTH];
    logic [4:0]       capQk [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_capture
            logic hitJ, hitK;
            assign hitJ      = cdb_valid && validReg[gi] && (qjReg[gi] == cdb_tag);
            assign hitK      = cdb_valid && validReg[gi] && (qkReg[gi] == cdb_tag);
            assign capQj[gi] = hitJ ? 5'd0 : qjReg[gi];
            assign capQk[gi] = hitK ? 5'd0 : qkReg[gi];
            assign capVj[gi] = hitJ ? cdb_data : vjReg[gi];
            assign capVk[gi] = hitK ? cdb_data : vkReg[gi];
        end
    endgenerate

    // Operand usage decoded from the opcode; unknown opcodes wait on both.
    logic useRs, useRt;
    always_comb begin
        useRs = 1'b1;
        useRt = 1'b1;
        case (issue_inst[31:26])
            6'd2, 6'd3: begin useRs = 1'b0; useRt = 1'b0; end
            6'd4, 6'd5: begin useRs = 1'b1; useRt = 1'b1; end
            6'd0, 6'd1: begin useRs = 1'b1; useRt = 1'b0; end
            default:    begin useRs = 1'b1; useRt = 1'b1; end
        endcase
    end

    logic fwdJ, fwdK, issueBlock;
`ifdef BRANCH_STATION_ISSUE_FWD_EN
    assign fwdJ       = useRs && cdb_valid && (issue_qj != 5'd0) && (issue_qj == cdb_tag);
    assign fwdK       = useRt && cdb_valid && (issue_qk != 5'd0) && (issue_qk == cdb_tag);
    assign issueBlock = 1'b0;
`else
    assign fwdJ       = 1'b0;
    assign fwdK       = 1'b0;
    // The broadcast would be missed by an entry written this cycle, so refuse it.
    assign issueBlock = cdb_valid && (((issue_qj != 5'd0) && (issue_qj == cdb_tag)) ||
                                      ((issue_qk != 5'd0) && (issue_qk == cdb_tag)));
`endif

    logic [4:0]  newQj, newQk;
    logic [31:0] newVj, newVk;
    assign newQj = (useRs && !fwdJ) ? issue_qj : 5'd0;
    assign newQk = (useRt && !fwdK) ? issue_qk : 5'd0;
    assign newVj = fwdJ ? cdb_data : issue_vj;
    assign newVk = fwdK ? cdb_data : issue_vk;

    logic fire, pop, wrIdx;
    assign issue_ready = (countReg < FULL_COUNT) && !issueBlock;
    assign out_valid   = validReg[0] && (qjReg[0] == 5'd0) && (qkReg[0] == 5'd0);
    assign fire        = issue_valid && issue_ready;
    assign pop         = out_valid && out_ready;
    // Write slot is count, or count-1 when the head leaves this cycle; fire
    // cannot happen at count 2, so one bit of count suffices.
    assign wrIdx       = pop ? countReg[1] : countReg[0];

    always_comb begin
        validNext = validReg;
        instNext  = instReg;
        addrNext  = addrReg;
        vjNext    = capVj;
        vkNext    = capVk;
        qjNext    = capQj;
        qkNext    = capQk;
        countNext = countReg;
        if (flush) begin
            validNext = '0;
            countNext = 2'd0;
            vjNext    = vjReg;
            vkNext    = vkReg;
            qjNext    = qjReg;
            qkNext    = qkReg;
        end else begin
            if (pop) begin
                validNext[0] = validReg[1];
                validNext[1] = 1'b0;
                // With nothing behind the head, keep its fields on the outputs.
                if (validReg[1]) begin
                    instNext[0] = instReg[1];
                    addrNext[0] = addrReg[1];
                    vjNext[0]   = capVj[1];
                    vkNext[0]   = capVk[1];
                    qjNext[0]   = capQj[1];
                    qkNext[0]   = capQk[1];
                end
            end
            if (fire) begin
                validNext[wrIdx] = 1'b1;
                instNext[wrIdx]  = issue_inst;
                addrNext[wrIdx]  = issue_addr;
                vjNext[wrIdx]    = newVj;
                vkNext[wrIdx]    = newVk;
                qjNext[wrIdx]    = newQj;
                qkNext[wrIdx]    = newQk;
            end
            countNext = countReg + {1'b0, fire} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validReg <= '0;
            countReg <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                instReg[i] <= '0;
                addrReg[i] <= '0;
                vjReg[i]   <= '0;
                vkReg[i]   <= '0;
                qjReg[i]   <= '0;
                qkReg[i]   <= '0;
            end
        end else begin
            validReg <= validNext;
            countReg <= countNext;
            instReg  <= instNext;
            addrReg  <= addrNext;
            vjReg    <= vjNext;
            vkReg    <= vkNext;
            qjReg    <= qjNext;
            qkReg    <= qkNext;
        end
    end

    assign out_inst = instReg[0];
    assign out_addr = addrReg[0];
    assign out_rs   = vjReg[0];
    assign out_rt   = vkReg[0];
    assign out_qj   = qjReg[0];
    assign out_qk   = qkReg[0];
    assign count    = countReg;

endmodule

// File: tb/tb_branch_station.sv
// -----------------------------------------------------------------------------
// tb_branch_station
//   Drives branch_station with directed sequences followed by random traffic
//   and compares every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_branch_station;
    logic        clk = 1'b0;
    logic        reset, flush, issue_valid, issue_ready;
    logic [31:0] issue_inst, issue_addr, issue_vj, issue_vk;
    logic [4:0]  issue_qj, issue_qk;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_addr, out_rs, out_rt;
    logic [4:0]  out_qj, out_qk;
    logic [1:0]  count;

    branch_station #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_inst(issue_inst), .issue_addr(issue_addr),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_rs(out_rs), .out_rt(out_rt),
        .out_qj(out_qj), .out_qk(out_qk), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [4:0]  qj;
        logic [4:0]  qk;
        logic        cv;
        logic [4:0]  ctag;
        logic [31:0] cdata;
        logic        ordy;
    } stim_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [4:0]  qj;
        logic [4:0]  qk;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic usesRs(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd1) || (op == 6'd4) || (op == 6'd5);
    endfunction

    function automatic logic usesRt(input logic [5:0] op);
        return (op == 6'd4) || (op == 6'd5);
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t issueStim(input int op, input logic [31:0] addr,
                                        input logic [31:0] vj, input logic [31:0] vk,
                                        input logic [4:0] qj, input logic [4:0] qk);
        stim_t s;
        s      = '0;
        s.iv   = 1'b1;
        s.inst = {6'(op), 26'h0001234};
        s.addr = addr;
        s.vj   = vj;
        s.vk   = vk;
        s.qj   = qj;
        s.qk   = qk;
        return s;
    endfunction

    // One clock cycle: check state at negedge, drive, check issue_ready, advance model.
    task automatic step(input stim_t s);
        ent_t e;
        logic expOv, expRdy, blocked, fire, pop, fj, fk;
        @(negedge clk);
        checkVal("count", 32'(count), 32'(q.size()));
        expOv = (q.size() > 0) && (q[0].qj == 5'd0) && (q[0].qk == 5'd0);
        checkVal("out_valid", 32'(out_valid), 32'(expOv));
        if (q.size() > 0) begin
            checkVal("out_qj", 32'(out_qj), 32'(q[0].qj));
            checkVal("out_qk", 32'(out_qk), 32'(q[0].qk));
            checkVal("out_inst", out_inst, q[0].inst);
            checkVal("out_addr", out_addr, q[0].addr);
            if (expOv && usesRs(q[0].inst[31:26])) checkVal("out_rs", out_rs, q[0].vj);
            if (expOv && usesRt(q[0].inst[31:26])) checkVal("out_rt", out_rt, q[0].vk);
        end
        reset = s.rst; flush = s.fl; issue_valid = s.iv;
        issue_inst = s.inst; issue_addr = s.addr;
        issue_vj = s.vj; issue_vk = s.vk; issue_qj = s.qj; issue_qk = s.qk;
        cdb_valid = s.cv; cdb_tag = s.ctag; cdb_data = s.cdata; out_ready = s.ordy;
        if (s.rst) q.delete();
        #1;
`ifdef BRANCH_STATION_ISSUE_FWD_EN
        blocked = 1'b0;
`else
        blocked = s.cv && (((s.qj != 0) && (s.qj == s.ctag)) || ((s.qk != 0) && (s.qk == s.ctag)));
`endif
        expRdy = (q.size() < 2) && !blocked;
        checkVal("issue_ready", 32'(issue_ready), 32'(expRdy));
        fire = s.iv && expRdy && !s.rst;
        pop  = expOv && s.ordy;
        @(posedge clk);
        if (s.rst || s.fl) begin
            q.delete();
        end else begin
            if (s.cv) begin
                foreach (q[i]) begin
                    if (q[i].qj == s.ctag) begin q[i].vj = s.cdata; q[i].qj = 0; end
                    if (q[i].qk == s.ctag) begin q[i].vk = s.cdata; q[i].qk = 0; end
                end
            end
            if (pop) void'(q.pop_front());
            if (fire) begin
                e.inst = s.inst;
                e.addr = s.addr;
`ifdef BRANCH_STATION_ISSUE_FWD_EN
                fj = usesRs(s.inst[31:26]) && s.cv && (s.qj != 0) && (s.qj == s.ctag);
                fk = usesRt(s.inst[31:26]) && s.cv && (s.qk != 0) && (s.qk == s.ctag);
`else
                fj = 1'b0;
                fk = 1'b0;
`endif
                e.vj = fj ? s.cdata : s.vj;
                e.vk = fk ? s.cdata : s.vk;
                e.qj = (usesRs(s.inst[31:26]) && !fj) ? s.qj : 5'd0;
                e.qk = (usesRt(s.inst[31:26]) && !fk) ? s.qk : 5'd0;
                q.push_back(e);
            end
        end
    endtask

    initial begin
        stim_t s;
        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0;
        issue_inst = '0; issue_addr = '0; issue_vj = '0; issue_vk = '0;
        issue_qj = '0; issue_qk = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        out_ready = 1'b0;
        #12;
        s = idleStim(); s.rst = 1'b1;
        step(s);
        step(idleStim());
        checkVal("rst_inst", out_inst, 32'h0);
        checkVal("rst_rs", out_rs, 32'h0);

        // beq ready at issue, then consumed
        step(issueStim(4, 32'h100, 32'd5, 32'd5, 5'd0, 5'd0));
        step(idleStim());
        s = idleStim(); s.ordy = 1'b1;
        step(s);

        // bne waiting on tag 3, woken by the CDB
        step(issueStim(5, 32'h200, 32'd0, 32'd9, 5'd3, 5'd0));
        s = idleStim(); s.cv = 1'b1; s.ctag = 5'd3; s.cdata = 32'h7;
        step(s);
        s = idleStim(); s.ordy = 1'b1;
        step(s);

        // head waiting on tag 4 blocks a ready entry behind it
        step(issueStim(5, 32'h300, 32'd0, 32'd1, 5'd4, 5'd0));
        step(issueStim(2, 32'h304, 32'd0, 32'd0, 5'd0, 5'd0));
        s = issueStim(4, 32'h308, 32'd1, 32'd1, 5'd0, 5'd0); s.ordy = 1'b1;
        step(s);
        s = idleStim(); s.cv = 1'b1; s.ctag = 5'd4; s.cdata = 32'h44; s.ordy = 1'b1;
        step(s);
        s = idleStim(); s.ordy = 1'b1;
        step(s);
        step(s);

        // count 1, head ready, simultaneous issue and pop
        step(issueStim(0, 32'h400, 32'h11, 32'd0, 5'd0, 5'd0));
        s = issueStim(1, 32'h404, 32'h22, 32'd0, 5'd0, 5'd0); s.ordy = 1'b1;
        step(s);
        step(s);
        s = idleStim(); s.ordy = 1'b1;
        step(s);

        // same-cycle issue with qj=6 and CDB tag 6
        s = issueStim(4, 32'h500, 32'd0, 32'd2, 5'd6, 5'd0);
        s.cv = 1'b1; s.ctag = 5'd6; s.cdata = 32'h66;
        step(s);
        s = idleStim(); s.ordy = 1'b1;
        step(s);
        step(s);

        // flush with two entries queued
        step(issueStim(5, 32'h600, 32'd0, 32'd0, 5'd7, 5'd0));
        step(issueStim(3, 32'h604, 32'd0, 32'd0, 5'd0, 5'd0));
        s = idleStim(); s.fl = 1'b1; s.cv = 1'b1; s.ctag = 5'd7; s.cdata = 32'h77;
        step(s);
        step(idleStim());

        // reset mid-stream with two entries queued
        step(issueStim(4, 32'h700, 32'd0, 32'd0, 5'd2, 5'd3));
        step(issueStim(2, 32'h704, 32'd0, 32'd0, 5'd0, 5'd0));
        s = idleStim(); s.rst = 1'b1;
        step(s);
        step(idleStim());

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            s       = '0;
            s.rst   = ($urandom_range(0, 199) == 0);
            s.fl    = ($urandom_range(0, 49) == 0);
            s.iv    = ($urandom_range(0, 3) != 0);
            s.inst  = {6'($urandom_range(0, 5)), 26'($urandom)};
            s.addr  = $urandom;
            s.vj    = $urandom;
            s.vk    = $urandom;
            s.qj    = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            s.qk    = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            s.cv    = ($urandom_range(0, 2) == 0);
            s.ctag  = 5'($urandom_range(1, 7));
            s.cdata = $urandom;
            s.ordy  = ($urandom_range(0, 9) < 7);
            step(s);
        end
        step(idleStim());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
